// File: rtl/dac_sequencer.sv
// Impedance-tomography excitation sequencer: steps through electrode pairs,
// streams a ROM waveform sample-by-sample to a handshaked DAC at a fixed tick
// rate, and flags underruns when the DAC cannot keep up with the tick.
module dac_sequencer #(
    parameter int CLK_DIV = 100,
    parameter int SAMPLES = 64,
    parameter int PERIODS = 8,
    parameter int N_ELEC  = 16,
    parameter int SETTLE  = 32,
    localparam int ADDR_W = $clog2(SAMPLES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_frame,
    input  logic              abort,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic              start_dac,
    output logic [15:0]       dac_val,
    input  logic              dac_done,
    output logic [3:0]        mux_src,
    output logic [3:0]        mux_sink,
    output logic              excite,
    output logic              busy,
    output logic              frame_done,
    output logic              underrun
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int SET_W = $clog2(SETTLE + 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SETTLE  = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_FETCH   = 3'd3;
    localparam logic [2:0] ST_LOAD    = 3'd4;
    localparam logic [2:0] ST_XFER    = 3'd5;
    localparam logic [2:0] ST_RELEASE = 3'd6;
    localparam logic [2:0] ST_DONE    = 3'd7;

    logic [2:0]        state;
    logic [ADDR_W-1:0] sample_cnt;
    logic [7:0]        period_cnt;
    logic [3:0]        src;
    logic [SET_W-1:0]  settle_cnt;
    logic [DIV_W-1:0]  div_cnt;
    logic              abort_pend;

    logic in_stream;
    logic in_handshake;
    logic tick;
    logic sample_last;
    logic period_last;
    logic src_last;

    // Decode state groupings and end-of-count conditions used by the FSM
    always_comb begin
        in_handshake = (state == ST_FETCH) || (state == ST_LOAD) ||
                       (state == ST_XFER)  || (state == ST_RELEASE);
        in_stream    = (state == ST_WAIT) || in_handshake;
        tick         = in_stream && (div_cnt == DIV_W'(CLK_DIV - 1));
        sample_last  = (sample_cnt == ADDR_W'(SAMPLES - 1));
        period_last  = (period_cnt == 8'(PERIODS - 1));
        src_last     = (src == 4'(N_ELEC - 1));
    end

    // Free-running sample-rate divider, held at zero whenever not streaming
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (!in_stream || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Main sequencer: pair stepping, sample fetch and DAC handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            sample_cnt <= '0;
            period_cnt <= '0;
            src        <= '0;
            settle_cnt <= '0;
            dac_val    <= 16'h8000;
            underrun   <= 1'b0;
            abort_pend <= 1'b0;
        end else begin
            if (tick && in_handshake) underrun <= 1'b1;
            if (abort && in_handshake) abort_pend <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (start_frame) begin
                        state      <= ST_SETTLE;
                        src        <= '0;
                        sample_cnt <= '0;
                        period_cnt <= '0;
                        settle_cnt <= '0;
                        underrun   <= 1'b0;
                        abort_pend <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (abort) begin
                        state <= ST_DONE;
                    end else if (settle_cnt == SET_W'(SETTLE - 1)) begin
                        settle_cnt <= '0;
                        state      <= ST_WAIT;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (abort) state <= ST_DONE;
                    else if (tick) state <= ST_FETCH;
                end
                ST_FETCH: state <= ST_LOAD;
                ST_LOAD: begin
                    dac_val <= rom_data;
                    state   <= ST_XFER;
                end
                ST_XFER: begin
                    if (dac_done) state <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (!dac_done) begin
                        if (abort || abort_pend) begin
                            state <= ST_DONE;
                        end else if (sample_last && period_last) begin
                            sample_cnt <= '0;
                            period_cnt <= '0;
                            if (src_last) begin
                                state <= ST_DONE;
                            end else begin
                                src        <= src + 1'b1;
                                settle_cnt <= '0;
                                state      <= ST_SETTLE;
                            end
                        end else begin
                            sample_cnt <= sample_last ? '0 : sample_cnt + 1'b1;
                            if (sample_last) period_cnt <= period_cnt + 1'b1;
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_DONE: begin
                    abort_pend <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs decoded directly from state so reset clears them immediately
    always_comb begin
        rom_addr   = sample_cnt;
        start_dac  = (state == ST_XFER);
        excite     = in_stream;
        busy       = (state != ST_IDLE);
        frame_done = (state == ST_DONE);
        mux_src    = src;
        mux_sink   = src_last ? 4'd0 : src + 1'b1;
    end

endmodule

// File: tb/tb_dac_sequencer.sv
// Bench for dac_sequencer: behavioural transfer-order model, ROM and DAC
// responders, and directed scenarios for frames, underrun, abort and reset.
module tb_dac_sequencer;

    localparam int CLK_DIV = 40;
    localparam int SAMPLES = 4;
    localparam int PERIODS = 2;
    localparam int N_ELEC  = 4;
    localparam int SETTLE  = 5;

    logic        clk;
    logic        rst;
    logic        start_frame;
    logic        abort;
    logic [1:0]  rom_addr;
    logic [15:0] rom_data;
    logic        start_dac;
    logic [15:0] dac_val;
    logic        dac_done;
    logic [3:0]  mux_src;
    logic [3:0]  mux_sink;
    logic        excite;
    logic        busy;
    logic        frame_done;
    logic        underrun;

    int assert_count = 0;
    int fail_count   = 0;
    int dac_delay    = 20;
    int dcnt         = 0;
    int exp_total    = 32;
    logic exp_underrun = 1'b0;

    dac_sequencer #(
        .CLK_DIV(CLK_DIV), .SAMPLES(SAMPLES), .PERIODS(PERIODS),
        .N_ELEC(N_ELEC), .SETTLE(SETTLE)
    ) dut (
        .clk(clk), .rst(rst), .start_frame(start_frame), .abort(abort),
        .rom_addr(rom_addr), .rom_data(rom_data), .start_dac(start_dac),
        .dac_val(dac_val), .dac_done(dac_done), .mux_src(mux_src),
        .mux_sink(mux_sink), .excite(excite), .busy(busy),
        .frame_done(frame_done), .underrun(underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous waveform ROM: word i holds 0x1000*(i+1)
    always @(posedge clk) rom_data <= 16'h1000 * (16'(rom_addr) + 16'd1);

    // DAC responder: done rises dac_delay cycles after start, drops after start falls
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dac_done <= 1'b0;
            dcnt     <= 0;
        end else if (!start_dac) begin
            dac_done <= 1'b0;
            dcnt     <= 0;
        end else if (!dac_done) begin
            if (dcnt == dac_delay - 1) dac_done <= 1'b1;
            dcnt <= dcnt + 1;
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Model of the k-th transfer of a frame, from the pair/period/sample nesting
    function automatic logic [15:0] model_dac(input int k);
        return 16'(4096 * ((k % SAMPLES) + 1));
    endfunction

    function automatic logic [3:0] model_src(input int k);
        return 4'((k / (SAMPLES * PERIODS)) % N_ELEC);
    endfunction

    function automatic logic [3:0] model_sink(input int k);
        return 4'(((k / (SAMPLES * PERIODS)) + 1) % N_ELEC);
    endfunction

    // Per-cycle compare process against the transfer-order model
    initial begin
        int xfer_idx   = 0;
        int settle_run = 0;
        logic prev_start = 1'b0;
        logic prev_done  = 1'b0;
        logic prev_fd    = 1'b0;
        logic prev_busy  = 1'b0;
        logic prev_exc   = 1'b0;
        logic [15:0] held_val = 16'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                xfer_idx   = 0;
                settle_run = 0;
                prev_start = 1'b0;
                prev_done  = 1'b0;
                prev_fd    = 1'b0;
                prev_busy  = 1'b0;
                prev_exc   = 1'b0;
            end else begin
                if (busy && !prev_busy) begin
                    xfer_idx   = 0;
                    settle_run = 0;
                end
                if (start_dac && !prev_start) begin
                    check_output("xfer_val", 32'(dac_val), 32'(model_dac(xfer_idx)));
                    check_output("xfer_src", 32'(mux_src), 32'(model_src(xfer_idx)));
                    check_output("xfer_sink", 32'(mux_sink), 32'(model_sink(xfer_idx)));
                    check_output("xfer_excite", 32'(excite), 32'd1);
                    held_val = dac_val;
                    xfer_idx++;
                end else if (start_dac && prev_start) begin
                    check_output("dac_hold", 32'(dac_val), 32'(held_val));
                end
                if (!start_dac && prev_start)
                    check_output("early_drop", 32'(prev_done), 32'd1);
                if (busy && !excite && !frame_done) settle_run++;
                if (excite && !prev_exc) begin
                    check_output("settle_len", 32'(settle_run), 32'(SETTLE));
                    settle_run = 0;
                end
                if (frame_done) begin
                    check_output("xfer_count", 32'(xfer_idx), 32'(exp_total));
                    check_output("underrun_end", 32'(underrun), 32'(exp_underrun));
                end
                if (prev_fd) check_output("busy_after_done", 32'(busy), 32'd0);
                prev_start = start_dac;
                prev_done  = dac_done;
                prev_fd    = frame_done;
                prev_busy  = busy;
                prev_exc   = excite;
            end
        end
    end

    // Bounded wait: 0 frame_done, 1 start_dac high, 2 start_dac low, 3 excite high
    task automatic wait_sig(input int which, input int limit);
        int n = 0;
        logic hit = 1'b0;
        while (!hit && n < limit) begin
            @(negedge clk);
            n++;
            case (which)
                0:       hit = frame_done;
                1:       hit = start_dac;
                2:       hit = !start_dac;
                default: hit = excite;
            endcase
        end
        if (!hit) begin
            assert_count++;
            fail_count++;
            $display("[TB] FAIL wait_timeout: event %0d not seen in %0d cycles, required within %0d",
                     which, n, limit);
        end
    endtask

    task automatic apply_stimulus(input logic with_abort);
        @(negedge clk);
        start_frame = 1'b1;
        abort       = with_abort;
        @(negedge clk);
        start_frame = 1'b0;
        abort       = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_start_dac"}, 32'(start_dac), 32'd0);
        check_output({tag, "_dac_val"}, 32'(dac_val), 32'h8000);
        check_output({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
        check_output({tag, "_src"}, 32'(mux_src), 32'd0);
        check_output({tag, "_sink"}, 32'(mux_sink), 32'd1);
        check_output({tag, "_excite"}, 32'(excite), 32'd0);
        check_output({tag, "_busy"}, 32'(busy), 32'd0);
        check_output({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        check_output({tag, "_underrun"}, 32'(underrun), 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        start_frame = 1'b0;
        abort       = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] normal frame");
        apply_stimulus(1'b0);
        check_output("busy_after_start", 32'(busy), 32'd1);
        wait_sig(1, 200);
        check_output("first_dac_val", 32'(dac_val), 32'h1000);
        check_output("first_rom_addr", 32'(rom_addr), 32'd0);
        wait_sig(0, 3000);
        check_output("last_src", 32'(mux_src), 32'd3);
        check_output("last_sink", 32'(mux_sink), 32'd0);
        repeat (3) @(negedge clk);
        check_output("hold_src", 32'(mux_src), 32'd3);

        $display("[TB] start_frame while busy");
        apply_stimulus(1'b0);
        repeat (300) @(negedge clk);
        start_frame = 1'b1;
        @(negedge clk);
        start_frame = 1'b0;
        wait_sig(0, 3000);

        $display("[TB] slow DAC underrun");
        dac_delay    = 60;
        exp_underrun = 1'b1;
        apply_stimulus(1'b0);
        wait_sig(0, 6000);
        repeat (5) @(negedge clk);
        check_output("underrun_sticky", 32'(underrun), 32'd1);

        $display("[TB] abort during transfer");
        dac_delay    = 20;
        exp_underrun = 1'b0;
        exp_total    = 3;
        apply_stimulus(1'b0);
        check_output("underrun_cleared", 32'(underrun), 32'd0);
        for (int i = 0; i < 3; i++) begin
            wait_sig(1, 200);
            if (i < 2) wait_sig(2, 200);
        end
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_output("start_held_abort", 32'(start_dac), 32'd1);
        wait_sig(0, 200);

        $display("[TB] start with abort, then abort while waiting");
        exp_total = 0;
        apply_stimulus(1'b1);
        check_output("start_wins_abort", 32'(busy), 32'd1);
        wait_sig(3, 100);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_output("abort_wait_done", 32'(frame_done), 32'd1);
        @(negedge clk);
        check_output("abort_wait_idle", 32'(busy), 32'd0);

        $display("[TB] reset mid transfer");
        exp_total = 32;
        apply_stimulus(1'b0);
        wait_sig(1, 200);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_reset_values("midrst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        apply_stimulus(1'b0);
        wait_sig(0, 3000);
        check_output("rerun_src", 32'(mux_src), 32'd3);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/dac_sequencer.md
DAC_SEQUENCER -- requirements
Module: dac_sequencer

Interface
REQ-001 Parameter CLK_DIV, default 100: clk cycles between sample ticks (min 40).
REQ-002 Parameter SAMPLES, default 64: waveform samples per period (power of 2, 4..256); ADDR_W = log2(SAMPLES).
REQ-003 Parameter PERIODS, default 8: waveform periods per electrode pair (1..255).
REQ-004 Parameter N_ELEC, default 16: electrode count (2..16).
REQ-005 Parameter SETTLE, default 32: clk cycles of mux settle after each pair switch (1..1023).
REQ-006 clk  in  1  system clock, all logic on rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 start_frame  in  1  one-cycle request to begin a frame; honoured only in IDLE.
REQ-009 abort  in  1  level/pulse request to end the frame early.
REQ-010 rom_addr  out  ADDR_W  waveform ROM address.
REQ-011 rom_data  in  16  ROM word, valid exactly 1 cycle after rom_addr.
REQ-012 start_dac  out  1  DAC transfer request, held high until dac_done.
REQ-013 dac_val  out  16  sample for the DAC, stable while start_dac high.
REQ-014 dac_done  in  1  DAC completion, held high until start_dac low.
REQ-015 mux_src  out  4  current-injection electrode index.
REQ-016 mux_sink  out  4  current-return electrode, (mux_src+1) mod N_ELEC.
REQ-017 excite  out  1  high while samples are being streamed for the current pair.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 frame_done  out  1  one-cycle pulse when a frame completes or an abort finishes.
REQ-020 underrun  out  1  sticky error flag, cleared only by rst or start_frame.

Function
REQ-021 States: IDLE, SETTLE, WAIT_TICK, FETCH, LOAD, XFER, RELEASE, DONE.
REQ-022 IDLE: start_frame -> SETTLE; mux_src=0, sample/period counters=0, underrun cleared, tick divider cleared.
REQ-023 SETTLE: count SETTLE cycles with excite low, then -> WAIT_TICK; divider cleared on exit.
REQ-024 Tick divider counts 0..CLK_DIV-1 in states WAIT_TICK..RELEASE; tick asserted when count = CLK_DIV-1.
REQ-025 WAIT_TICK: on tick -> FETCH, driving rom_addr = sample counter.
REQ-026 FETCH -> LOAD after exactly 1 cycle; LOAD registers rom_data into dac_val, raises start_dac, -> XFER.
REQ-027 XFER: hold start_dac high and dac_val constant until dac_done=1, then drop start_dac, -> RELEASE.
REQ-028 RELEASE: wait for dac_done=0, then advance counters and choose next state.
REQ-029 Counter advance: sample counter wraps SAMPLES-1 -> 0; on wrap the period counter increments.
REQ-030 Period counter reaching PERIODS: mux_src increments, counters clear, -> SETTLE; if mux_src was N_ELEC-1 -> DONE instead.
REQ-031 Otherwise RELEASE -> WAIT_TICK.
REQ-032 DONE: pulse frame_done 1 cycle, -> IDLE; mux_src/mux_sink hold last values.
REQ-033 A tick occurring in FETCH, LOAD, XFER or RELEASE sets underrun and is dropped (no catch-up sample).
REQ-034 abort in IDLE ignored; in SETTLE or WAIT_TICK -> DONE next cycle.
REQ-035 abort in FETCH/LOAD/XFER/RELEASE is latched; the handshake completes through RELEASE, then -> DONE.
REQ-036 start_dac never deasserts before dac_done=1, including under abort.
REQ-037 excite high in WAIT_TICK, FETCH, LOAD, XFER and RELEASE; low elsewhere.
REQ-038 start_frame outside IDLE ignored; start_frame and abort together in IDLE -> start.

Reset
REQ-039 rst forces IDLE; start_dac=0, dac_val=16'h8000, rom_addr=0, mux_src=0, mux_sink=1, excite=0, busy=0, frame_done=0, underrun=0.
REQ-040 rst mid-transfer drops start_dac immediately; no handshake completion required.

Verification (CLK_DIV=40, SAMPLES=4, PERIODS=2, N_ELEC=4, SETTLE=5; ROM[i]=16'h1000*(i+1); DAC model done 20 cycles after start)
REQ-041 start_frame -> 5 settle cycles, then 32 transfers per frame, dac_val sequence 1000,2000,3000,4000 repeating, frame_done after 4th pair.
REQ-042 Pair stepping: (src,sink) = (0,1),(1,2),(2,3),(3,0); excite low for exactly 5 cycles at each switch.
REQ-043 DAC model delays done 60 cycles -> underrun=1, no sample skipped in ROM order, remains set until next start_frame.
REQ-044 abort during XFER -> start_dac held until done, RELEASE completes, frame_done pulses, busy low next cycle.
REQ-045 rst asserted during XFER -> all outputs at REQ-039 values same cycle; new start_frame runs a full frame normally.
REQ-046 start_frame pulsed while busy -> ignored, frame sequence unchanged.
